mvb_crc_gen: RTL

//  Transmit-side MVB check-sequence generator, the counterpart of the receive-side CRC check.

---
 rtl/mvb_pkg.sv | 33 +++
 rtl/mvb_crc_reg.sv | 33 +++
 rtl/mvb_crc_gen.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mvb_pkg.sv
// Shared MVB definitions: FSM state encoding, check-code width and the per-bit
// check-code update shared by the transmit generator and the receive checker.
package mvb_pkg;

    localparam int MVB_CRC_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } mvb_state_t;

    // Next check-code value after absorbing one serial bit d.
    // Bit 0 carries parity over the shifted-out register contents.
    function automatic logic [MVB_CRC_W-1:0] mvb_crc_next(
        input logic [MVB_CRC_W-1:0] crc,
        input logic                 d
    );
        logic                 fb;
        logic [MVB_CRC_W-1:0] n;
        fb   = crc[7] ^ d;
        n[1] = fb;
        n[2] = crc[1];
        n[3] = crc[2] ^ fb;
        n[4] = crc[3];
        n[5] = crc[4];
        n[6] = crc[5] ^ fb;
        n[7] = crc[6] ^ fb;
        n[0] = d ^ (^crc[7:1]) ^ fb;
        return n;
    endfunction

endpackage

// File: rtl/mvb_crc_reg.sv
// 8-bit MVB check-code register: synchronous clear takes priority over a
// bit update; also exposes the code value that the current bit would produce.
import mvb_pkg::*;

module mvb_crc_reg (
    input  logic                 clk_3M,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_upd,
    input  logic                 i_d,
    output logic [MVB_CRC_W-1:0] o_crc_next
);

    logic [MVB_CRC_W-1:0] r_crc;
    logic [MVB_CRC_W-1:0] w_next;

    assign w_next     = mvb_crc_next(r_crc, i_d);
    assign o_crc_next = w_next;

    // Check-code register: clear at block end, update on each accepted bit
    always_ff @(posedge clk_3M) begin
        if (!rst) begin
            r_crc <= {MVB_CRC_W{1'b0}};
        end else if (i_clr) begin
            r_crc <= {MVB_CRC_W{1'b0}};
        end else if (i_upd) begin
            r_crc <= w_next;
        end else begin
            r_crc <= r_crc;
        end
    end

endmodule

// File: rtl/mvb_crc_gen.sv
// MVB transmit check-sequence generator: passes frame bits through and appends
// an 8-bit code MSB first after each block and after the frame's last bit.
// Optional MVB_CRC_CNT_EN adds the crc_cnt count of emitted check sequences.
import mvb_pkg::*;

module mvb_crc_gen #(
    parameter int BLOCK_BITS = 64
) (
    input  logic        clk_3M,
    input  logic        rst,
    input  logic        data_valid,
    input  logic        data_in,
    input  logic        frame_end,
    output logic        data_ready,
    output logic        tx_valid,
    output logic        tx_bit,
    output logic        crc_phase,
    output logic        frame_done
`ifdef MVB_CRC_CNT_EN
    ,
    output logic [15:0] crc_cnt
`endif
);

    localparam logic [6:0] BLK_LAST = 7'(BLOCK_BITS - 1);

    mvb_state_t           r_state;
    logic [6:0]           r_bit_cnt;
    logic [2:0]           r_idx;
    logic [MVB_CRC_W-1:0] r_shift;
    logic                 r_eof;
    logic                 r_data_ready;
    logic                 r_tx_valid;
    logic                 r_tx_bit;
    logic                 r_crc_phase;
    logic                 r_frame_done;

    logic                 w_accept;
    logic                 w_block_end;
    logic [MVB_CRC_W-1:0] w_crc_next;

    assign w_accept    = data_valid && r_data_ready;
    assign w_block_end = frame_end || (r_bit_cnt == BLK_LAST);

    mvb_crc_reg u_crc_reg (
        .clk_3M     (clk_3M),
        .rst        (rst),
        .i_clr      (w_accept && w_block_end),
        .i_upd      (w_accept),
        .i_d        (data_in),
        .o_crc_next (w_crc_next)
    );

    // Frame FSM: pass data bits, then shift out the latched code
    always_ff @(posedge clk_3M) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= 7'd0;
            r_idx        <= 3'd0;
            r_shift      <= {MVB_CRC_W{1'b0}};
            r_eof        <= 1'b0;
            r_data_ready <= 1'b1;
            r_tx_valid   <= 1'b0;
            r_tx_bit     <= 1'b0;
            r_crc_phase  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE, DATA: begin
                    if (w_accept) begin
                        r_tx_valid  <= 1'b1;
                        r_tx_bit    <= data_in;
                        r_crc_phase <= 1'b0;
                        if (w_block_end) begin
                            r_shift      <= w_crc_next;
                            r_eof        <= frame_end;
                            r_bit_cnt    <= 7'd0;
                            r_idx        <= 3'd0;
                            r_data_ready <= 1'b0;
                            r_state      <= CRC;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 7'd1;
                            r_state   <= DATA;
                        end
                    end else begin
                        r_tx_valid  <= 1'b0;
                        r_crc_phase <= 1'b0;
                    end
                end
                CRC: begin
                    r_tx_valid  <= 1'b1;
                    r_crc_phase <= 1'b1;
                    r_tx_bit    <= r_shift[7];
                    r_shift     <= {r_shift[6:0], 1'b0};
                    r_idx       <= r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        r_data_ready <= 1'b1;
                        r_frame_done <= r_eof;
                        r_state      <= r_eof ? IDLE : DATA;
                    end else begin
                        r_state <= CRC;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_data_ready <= 1'b1;
                    r_tx_valid   <= 1'b0;
                    r_crc_phase  <= 1'b0;
                end
            endcase
        end
    end

    assign data_ready = r_data_ready;
    assign tx_valid   = r_tx_valid;
    assign tx_bit     = r_tx_bit;
    assign crc_phase  = r_crc_phase;
    assign frame_done = r_frame_done;

`ifdef MVB_CRC_CNT_EN
    logic [15:0] r_crc_cnt;

    // Count check sequences, advancing with each 8th check bit
    always_ff @(posedge clk_3M) begin
        if (!rst) begin
            r_crc_cnt <= 16'd0;
        end else if (r_state == CRC && r_idx == 3'd7) begin
            r_crc_cnt <= r_crc_cnt + 16'd1;
        end else begin
            r_crc_cnt <= r_crc_cnt;
        end
    end

    assign crc_cnt = r_crc_cnt;
`endif

endmodule
